// File: rtl/apb_chk_pkg.sv
// Shared types and helpers for the APB3 protocol checker: FSM states, error codes
// and a saturating increment used by every statistics counter.
package apb_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_chk_state_e;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_MULTI_PSEL      = 3'd1,
        ERR_EN_NO_SETUP     = 3'd2,
        ERR_SETUP_NO_ACCESS = 3'd3,
        ERR_UNSTABLE        = 3'd4,
        ERR_PSEL_DROP       = 3'd5,
        ERR_TIMEOUT         = 3'd6
    } apb_chk_err_e;

    localparam int ERR_NUM = 6;
    localparam int SAT_W   = 32;

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned width);
        logic [SAT_W-1:0] max_value;
        max_value = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        return (value >= max_value) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/apb_chk_wait_timer.sv
// Wait-state counter for the ACCESS phase: load to 1 on the first access cycle,
// count each further wait cycle, and flag the cycle that reaches the limit.
module apb_chk_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] count_reg;

    assign expire = inc && (({1'b0, count_reg} + 1'b1) == (TW + 1)'(TIMEOUT_CYCLES));

    // Anything other than load/continue means the transfer is over, so drop to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= '0;
        else if (load)
            count_reg <= TW'(1);
        else if (inc && !expire)
            count_reg <= count_reg + 1'b1;
        else
            count_reg <= '0;
    end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3 protocol checker: phase FSM, violation detection with a one-cycle
// registered error pulse, sticky error flags and saturating statistics counters.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int PADDR_WIDTH    = 32,
    parameter int PWDATA_WIDTH   = 32,
    parameter int PRDATA_WIDTH   = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    prwd,
    input  logic [PWDATA_WIDTH-1:0] pwdata,
    input  logic                    penable,
    input  logic [NUM_SLAVES-1:0]   psel,
    input  logic [PRDATA_WIDTH-1:0] prdata,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic                    check_en,
    input  logic                    clear,
    output logic                    err_valid,
    output logic [2:0]              err_code,
    output logic [PADDR_WIDTH-1:0]  err_addr,
    output logic [ERR_NUM-1:0]      err_sticky,
    output logic [CNT_WIDTH-1:0]    xfer_count,
    output logic [CNT_WIDTH-1:0]    slverr_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic                    busy
);
    apb_chk_state_e          state_reg;
    logic [NUM_SLAVES-1:0]   cap_sel_reg;
    logic [PADDR_WIDTH-1:0]  cap_addr_reg;
    logic                    cap_rwd_reg;
    logic [PWDATA_WIDTH-1:0] cap_wdata_reg;

    logic                    unused_prdata;
    logic [NUM_SLAVES-1:0]   psel_m1;
    logic                    sel_any, sel_same, unstable, setup_bad;
    logic                    setup_ok, access_ok, complete;
    logic                    timer_load, timer_inc, timer_expire;
    logic [ERR_NUM-1:0]      err_bits;
    logic                    report;
    apb_chk_err_e            code_next;

    assign unused_prdata = ^prdata;

    assign psel_m1   = psel - 1'b1;
    assign sel_any   = |psel;
    assign sel_same  = (psel == cap_sel_reg);
    assign unstable  = (paddr != cap_addr_reg) || (prwd != cap_rwd_reg) ||
                       (cap_rwd_reg && (pwdata != cap_wdata_reg));
    assign setup_bad = !penable || !sel_same;

    assign setup_ok   = (state_reg == SETUP) && !setup_bad && !unstable;
    assign access_ok  = (state_reg == ACCESS) && sel_any && sel_same && !unstable;
    assign complete   = (setup_ok || access_ok) && pready;
    assign timer_load = setup_ok && !pready;
    assign timer_inc  = access_ok && !pready;

    // Bit i of err_bits corresponds to error code i+1.
    assign err_bits = {
        timer_expire,
        (state_reg == ACCESS) && !sel_any,
        ((state_reg == SETUP) && unstable) ||
            ((state_reg == ACCESS) && sel_any && (!sel_same || unstable)),
        (state_reg == SETUP) && setup_bad,
        (state_reg == IDLE) && sel_any && penable,
        |(psel & psel_m1)
    };

    assign report = check_en && (|err_bits);

    always_comb begin
        code_next = ERR_NONE;
        for (int i = ERR_NUM - 1; i >= 0; i--)
            if (err_bits[i])
                code_next = apb_chk_err_e'(3'(i + 1));
    end

    apb_chk_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (pclock),
        .rst    (preset),
        .load   (timer_load),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    always_ff @(posedge pclock or posedge preset) begin
        if (preset) begin
            state_reg     <= IDLE;
            cap_sel_reg   <= '0;
            cap_addr_reg  <= '0;
            cap_rwd_reg   <= 1'b0;
            cap_wdata_reg <= '0;
            err_valid     <= 1'b0;
            err_code      <= '0;
            err_addr      <= '0;
            err_sticky    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_any && !penable) begin
                        state_reg     <= SETUP;
                        cap_sel_reg   <= psel;
                        cap_addr_reg  <= paddr;
                        cap_rwd_reg   <= prwd;
                        cap_wdata_reg <= pwdata;
                    end
                end
                SETUP:   state_reg <= timer_load ? ACCESS : IDLE;
                ACCESS:  state_reg <= (timer_inc && !timer_expire) ? ACCESS : IDLE;
                default: state_reg <= IDLE;
            endcase

            err_valid <= report;
            err_code  <= report ? code_next : ERR_NONE;
            // Bus-level errors have no captured transfer, so they report the live address.
            if (report)
                err_addr <= (code_next == ERR_MULTI_PSEL || code_next == ERR_EN_NO_SETUP)
                            ? paddr : cap_addr_reg;

            if (clear)
                err_sticky <= report ? err_bits : '0;
            else if (report)
                err_sticky <= err_sticky | err_bits;
        end
    end

    logic [2:0]           cnt_event;
    logic [CNT_WIDTH-1:0] cnt_value [3];

    assign cnt_event = {report, complete && pslverr, complete};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] count_reg;
            logic [SAT_W-1:0]     inc_wide;

            assign inc_wide       = sat_inc(SAT_W'(count_reg), CNT_WIDTH);
            assign cnt_value[gi]  = count_reg;

            // A coincident event beats clear: the counter restarts at 1.
            always_ff @(posedge pclock or posedge preset) begin
                if (preset)
                    count_reg <= '0;
                else if (cnt_event[gi])
                    count_reg <= clear ? CNT_WIDTH'(1) : CNT_WIDTH'(inc_wide);
                else if (clear)
                    count_reg <= '0;
            end
        end
    endgenerate

    assign xfer_count   = cnt_value[0];
    assign slverr_count = cnt_value[1];
    assign err_count    = cnt_value[2];
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed self-checking bench for apb_protocol_checker (16 slaves, 4-cycle timeout).
module tb_apb_protocol_checker;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 16;
    localparam int CW = 16;

    logic          pclock;
    logic          preset;
    logic [AW-1:0] paddr;
    logic          prwd;
    logic [DW-1:0] pwdata;
    logic          penable;
    logic [NS-1:0] psel;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          check_en;
    logic          clear;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [5:0]    err_sticky;
    logic [CW-1:0] xfer_count;
    logic [CW-1:0] slverr_count;
    logic [CW-1:0] err_count;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_protocol_checker #(
        .PADDR_WIDTH   (AW),
        .PWDATA_WIDTH  (DW),
        .PRDATA_WIDTH  (DW),
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (CW)
    ) dut (
        .pclock      (pclock),
        .preset      (preset),
        .paddr       (paddr),
        .prwd        (prwd),
        .pwdata      (pwdata),
        .penable     (penable),
        .psel        (psel),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .check_en    (check_en),
        .clear       (clear),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_addr    (err_addr),
        .err_sticky  (err_sticky),
        .xfer_count  (xfer_count),
        .slverr_count(slverr_count),
        .err_count   (err_count),
        .busy        (busy)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclock);
        #1;
    endtask

    task automatic bus_idle();
        psel    = '0;
        penable = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    task automatic bus_setup(input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                             input logic wr, input logic [DW-1:0] data);
        psel    = sel;
        paddr   = addr;
        prwd    = wr;
        pwdata  = data;
        penable = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        preset   = 1'b1;
        paddr    = '0;
        prwd     = 1'b0;
        pwdata   = '0;
        prdata   = '0;
        check_en = 1'b1;
        clear    = 1'b0;
        bus_idle();
        repeat (2) @(posedge pclock);
        #1 preset = 1'b0;

        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err_valid", 64'(err_valid), 64'd0);
        chk("reset_err_code", 64'(err_code), 64'd0);
        chk("reset_sticky", 64'(err_sticky), 64'd0);
        chk("reset_xfer", 64'(xfer_count), 64'd0);
        chk("reset_err_count", 64'(err_count), 64'd0);
        $display("reset: busy=%0d xfer=%0d err_count=%0d", busy, xfer_count, err_count);

        // Zero-wait write.
        bus_setup(16'h0004, 32'h100, 1'b1, 32'hDEAD_BEEF);
        step();
        chk("wr_setup_busy", 64'(busy), 64'd1);
        chk("wr_setup_no_err", 64'(err_valid), 64'd0);
        penable = 1'b1;
        pready  = 1'b1;
        step();
        chk("wr_done_busy", 64'(busy), 64'd0);
        chk("wr_done_xfer", 64'(xfer_count), 64'd1);
        chk("wr_done_no_err", 64'(err_valid), 64'd0);
        bus_idle();
        step();
        chk("wr_idle_no_err", 64'(err_valid), 64'd0);
        chk("wr_err_count", 64'(err_count), 64'd0);
        $display("write: xfer=%0d err_count=%0d", xfer_count, err_count);

        // Read with 3 wait states and pslverr; pwdata wiggles but reads ignore it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_xfer", 64'(xfer_count), 64'd0);
        bus_setup(16'h0002, 32'h200, 1'b0, 32'h1111_1111);
        step();
        penable = 1'b1;
        step();
        chk("rd_wait1_busy", 64'(busy), 64'd1);
        chk("rd_wait1_no_err", 64'(err_valid), 64'd0);
        pwdata = 32'h2222_2222;
        step();
        chk("rd_wait2_no_err", 64'(err_valid), 64'd0);
        step();
        chk("rd_wait3_busy", 64'(busy), 64'd1);
        pready  = 1'b1;
        pslverr = 1'b1;
        step();
        chk("rd_done_xfer", 64'(xfer_count), 64'd1);
        chk("rd_done_slverr", 64'(slverr_count), 64'd1);
        chk("rd_done_no_err", 64'(err_valid), 64'd0);
        chk("rd_done_busy", 64'(busy), 64'd0);
        bus_idle();
        step();
        chk("rd_err_count", 64'(err_count), 64'd0);
        $display("read: xfer=%0d slverr=%0d err_count=%0d", xfer_count, slverr_count, err_count);

        // Address change in the second wait state.
        bus_setup(16'h0004, 32'h100, 1'b1, 32'hCAFE_0001);
        step();
        penable = 1'b1;
        step();
        chk("unst_wait1_no_err", 64'(err_valid), 64'd0);
        paddr = 32'h104;
        step();
        chk("unst_valid", 64'(err_valid), 64'd1);
        chk("unst_code", 64'(err_code), 64'd4);
        chk("unst_addr", 64'(err_addr), 64'h100);
        chk("unst_sticky", 64'(err_sticky), 64'b001000);
        chk("unst_err_count", 64'(err_count), 64'd1);
        chk("unst_busy", 64'(busy), 64'd0);
        bus_idle();
        step();
        chk("unst_pulse_end", 64'(err_valid), 64'd0);
        chk("unst_code_end", 64'(err_code), 64'd0);
        $display("unstable: code=4 expected, err_count=%0d sticky=%b", err_count, err_sticky);

        // Two selects with penable straight from IDLE.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_sticky", 64'(err_sticky), 64'd0);
        psel    = 16'h0003;
        paddr   = 32'h300;
        penable = 1'b1;
        step();
        chk("multi_valid", 64'(err_valid), 64'd1);
        chk("multi_code", 64'(err_code), 64'd1);
        chk("multi_addr", 64'(err_addr), 64'h300);
        chk("multi_sticky", 64'(err_sticky), 64'b000011);
        chk("multi_err_count", 64'(err_count), 64'd1);
        chk("multi_busy", 64'(busy), 64'd0);
        bus_idle();
        step();
        chk("multi_pulse_end", 64'(err_valid), 64'd0);
        chk("multi_err_count_hold", 64'(err_count), 64'd1);
        $display("multi_psel: err_count=%0d sticky=%b", err_count, err_sticky);

        // Timeout: pready held low.
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus_setup(16'h0001, 32'h400, 1'b0, 32'h0);
        step();
        penable = 1'b1;
        step();
        chk("to_c1_no_err", 64'(err_valid), 64'd0);
        step();
        chk("to_c2_no_err", 64'(err_valid), 64'd0);
        step();
        chk("to_c3_no_err", 64'(err_valid), 64'd0);
        chk("to_c3_busy", 64'(busy), 64'd1);
        step();
        chk("to_valid", 64'(err_valid), 64'd1);
        chk("to_code", 64'(err_code), 64'd6);
        chk("to_addr", 64'(err_addr), 64'h400);
        chk("to_sticky", 64'(err_sticky), 64'b100000);
        chk("to_busy", 64'(busy), 64'd0);
        bus_idle();
        step();
        bus_setup(16'h0008, 32'h500, 1'b1, 32'h5555_AAAA);
        step();
        penable = 1'b1;
        pready  = 1'b1;
        step();
        chk("to_after_xfer", 64'(xfer_count), 64'd1);
        chk("to_after_no_err", 64'(err_valid), 64'd0);
        chk("to_after_err_count", 64'(err_count), 64'd1);
        bus_idle();
        step();
        $display("timeout: xfer=%0d err_count=%0d sticky=%b", xfer_count, err_count, err_sticky);

        // Reporting suppressed, then clear, then clear coinciding with a fault.
        check_en = 1'b0;
        psel     = 16'h0003;
        penable  = 1'b1;
        step();
        chk("dis_no_pulse", 64'(err_valid), 64'd0);
        chk("dis_err_count", 64'(err_count), 64'd1);
        chk("dis_sticky", 64'(err_sticky), 64'b100000);
        bus_idle();
        check_en = 1'b1;
        clear    = 1'b1;
        step();
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        chk("clr_xfer", 64'(xfer_count), 64'd0);
        chk("clr_err_count", 64'(err_count), 64'd0);
        chk("clr_no_pulse", 64'(err_valid), 64'd0);
        psel    = 16'h0003;
        paddr   = 32'h600;
        penable = 1'b1;
        step();
        chk("clrf_valid", 64'(err_valid), 64'd1);
        chk("clrf_err_count", 64'(err_count), 64'd1);
        chk("clrf_sticky", 64'(err_sticky), 64'b000011);
        clear = 1'b0;
        bus_idle();
        step();
        $display("clear: err_count=%0d sticky=%b", err_count, err_sticky);

        // Two back-to-back transfers, clear landing on the second completion.
        bus_setup(16'h0002, 32'h700, 1'b1, 32'h7);
        step();
        penable = 1'b1;
        pready  = 1'b1;
        step();
        chk("b2b_a_xfer", 64'(xfer_count), 64'd1);
        bus_setup(16'h0002, 32'h704, 1'b1, 32'h8);
        step();
        penable = 1'b1;
        pready  = 1'b1;
        clear   = 1'b1;
        step();
        clear = 1'b0;
        chk("b2b_b_xfer", 64'(xfer_count), 64'd1);
        chk("b2b_b_err_count", 64'(err_count), 64'd0);
        chk("b2b_b_sticky", 64'(err_sticky), 64'd0);
        $display("b2b_clear: xfer=%0d err_count=%0d", xfer_count, err_count);

        // Asynchronous reset in the middle of a wait state.
        bus_setup(16'h0002, 32'h800, 1'b0, 32'h0);
        step();
        penable = 1'b1;
        step();
        chk("arst_pre_busy", 64'(busy), 64'd1);
        #2 preset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_xfer", 64'(xfer_count), 64'd0);
        chk("arst_no_err", 64'(err_valid), 64'd0);
        #1 preset = 1'b0;
        bus_idle();
        step();
        chk("arst_after_no_err", 64'(err_valid), 64'd0);
        chk("arst_after_busy", 64'(busy), 64'd0);
        $display("async_reset: busy=%0d xfer=%0d", busy, xfer_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
